// File: rtl/mem_bus_responder_pkg.sv
// Shared constants and address decode for the memory-side bus responder.
package mem_bus_responder_pkg;

   localparam logic [1:0]  IO_REGION    = 2'b11;
   localparam logic [17:0] IO_UART_ADDR = 18'h30000;
   localparam logic [17:0] IO_END_ADDR  = 18'h30004;

   // Target selected by the decoded low 18 address bits.
   typedef enum logic [1:0] {
      SEL_RAM      = 2'd0,
      SEL_UART     = 2'd1,
      SEL_END      = 2'd2,
      SEL_IO_OTHER = 2'd3
   } bus_sel_e;

   // The IO window is the top quarter of the 18-bit space; everything else is RAM.
   function automatic bus_sel_e decode_sel(input logic [17:0] addr);
      bus_sel_e sel;
      if (addr[17:16] != IO_REGION) begin
         sel = SEL_RAM;
      end else if (addr == IO_UART_ADDR) begin
         sel = SEL_UART;
      end else if (addr == IO_END_ADDR) begin
         sel = SEL_END;
      end else begin
         sel = SEL_IO_OTHER;
      end
      return sel;
   endfunction

endpackage

// File: rtl/mem_bus_responder_io_tx_fifo.sv
// UART TX FIFO: a full FIFO still accepts a push when the head is popped in the same cycle.
module io_tx_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_i,
   input  logic [7:0]                 din_i,
   input  logic                       pop_i,
   output logic [7:0]                 dout_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       full_o,
   output logic                       empty_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [7:0]       mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign full_o    = (count_q == CNT_W'(DEPTH));
   assign empty_o   = (count_q == {CNT_W{1'b0}});
   assign count_o   = count_q;
   assign dout_o    = mem_q[rd_ptr_q];
   assign pop_ok_s  = pop_i && !empty_o;
   assign push_ok_s = push_i && (!full_o || pop_ok_s);

   // Next pointer and occupancy; pointers wrap naturally at the power-of-2 depth.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok_s) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage is data-only and needs no reset; occupancy is tracked by count.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

   // Pointer and count state; reset discards the FIFO contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         count_q  <= {CNT_W{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side bus responder: byte RAM with 1-cycle read latency plus UART/end-of-sim IO window.
module mem_bus_responder
   import mem_bus_responder_pkg::*;
#(
   parameter int ADDR_WID      = 17,
   parameter int TX_FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] mem_a,
   input  logic [7:0]  mem_dout,
   input  logic        mem_wr,
   output logic [7:0]  mem_din,
   output logic        io_buffer_full,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ack,
   output logic        sim_end,
   output logic [7:0]  end_code,
   output logic        io_overflow
);

   localparam int CNT_W = $clog2(TX_FIFO_DEPTH) + 1;

   logic [7:0]          ram_q [2**ADDR_WID];
   logic [ADDR_WID-1:0] idx_s;
   bus_sel_e            sel_s;
   logic                unused_addr_s;

   logic [7:0]          mem_din_q, mem_din_d;
   logic                rx_ack_q, rx_ack_d;
   logic                sim_end_q, sim_end_d;
   logic [7:0]          end_code_q, end_code_d;
   logic                io_overflow_q, io_overflow_d;

   logic                push_s;
   logic                pop_s;
   logic                fifo_full_s;
   logic                fifo_empty_s;
   logic [CNT_W-1:0]    fifo_count_s;

   assign idx_s         = mem_a[ADDR_WID-1:0];
   assign sel_s         = decode_sel(mem_a[17:0]);
   assign unused_addr_s = ^mem_a[31:18];

   assign push_s         = mem_wr && (sel_s == SEL_UART);
   assign tx_valid       = !fifo_empty_s;
   assign pop_s          = tx_valid && tx_ready;
   // One slot of margin: the controller samples this one cycle before its write lands.
   assign io_buffer_full = (fifo_count_s >= CNT_W'(TX_FIFO_DEPTH - 1));

   io_tx_fifo #(
      .DEPTH (TX_FIFO_DEPTH)
   ) u_tx_fifo (
      .clk     (clk),
      .rst_n   (rst),
      .push_i  (push_s),
      .din_i   (mem_dout),
      .pop_i   (pop_s),
      .dout_o  (tx_data),
      .count_o (fifo_count_s),
      .full_o  (fifo_full_s),
      .empty_o (fifo_empty_s)
   );

   // RAM write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_wr && (sel_s == SEL_RAM)) begin
         ram_q[idx_s] <= mem_dout;
      end
   end

   // Read mux and IO side effects; RAM read sees the pre-write byte.
   always_comb begin
      mem_din_d     = 8'h00;
      rx_ack_d      = 1'b0;
      sim_end_d     = sim_end_q;
      end_code_d    = end_code_q;
      io_overflow_d = io_overflow_q;
      case (sel_s)
         SEL_RAM: begin
            mem_din_d = ram_q[idx_s];
         end
         SEL_UART: begin
            if (!mem_wr && rx_valid) begin
               mem_din_d = rx_data;
               rx_ack_d  = 1'b1;
            end else begin
               mem_din_d = 8'h00;
               rx_ack_d  = 1'b0;
            end
            if (push_s && fifo_full_s && !pop_s) begin
               io_overflow_d = 1'b1;
            end else begin
               io_overflow_d = io_overflow_q;
            end
         end
         SEL_END: begin
            if (mem_wr) begin
               sim_end_d  = 1'b1;
               end_code_d = mem_dout;
            end else begin
               mem_din_d = {7'b000_0000, io_buffer_full};
            end
         end
         default: begin
            mem_din_d = 8'h00;
         end
      endcase
   end

   // Registered responder outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_din_q     <= 8'h00;
         rx_ack_q      <= 1'b0;
         sim_end_q     <= 1'b0;
         end_code_q    <= 8'h00;
         io_overflow_q <= 1'b0;
      end else begin
         mem_din_q     <= mem_din_d;
         rx_ack_q      <= rx_ack_d;
         sim_end_q     <= sim_end_d;
         end_code_q    <= end_code_d;
         io_overflow_q <= io_overflow_d;
      end
   end

   assign mem_din     = mem_din_q;
   assign rx_ack      = rx_ack_q;
   assign sim_end     = sim_end_q;
   assign end_code    = end_code_q;
   assign io_overflow = io_overflow_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Scoreboard bench for mem_bus_responder: driver pushes expected post-edge state, monitor compares.
module tb_mem_bus_responder;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] mem_a;
   logic [7:0]  mem_dout;
   logic        mem_wr;
   logic [7:0]  mem_din;
   logic        io_buffer_full;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ack;
   logic        sim_end;
   logic [7:0]  end_code;
   logic        io_overflow;

   mem_bus_responder #(.ADDR_WID(17), .TX_FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr),
      .mem_din(mem_din), .io_buffer_full(io_buffer_full), .tx_valid(tx_valid),
      .tx_data(tx_data), .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data),
      .rx_ack(rx_ack), .sim_end(sim_end), .end_code(end_code), .io_overflow(io_overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         chk_din;
      logic [7:0] din;
      logic       ack;
      logic       se;
      logic [7:0] ec;
      logic       ovf;
      logic       tv;
      logic [7:0] td;
      logic       bf;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic [7:0] ram_m [int];
   logic [7:0] txq_m [$];
   logic       ovf_m = 1'b0;
   logic       se_m  = 1'b0;
   logic [7:0] ec_m  = 8'h00;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One bus cycle: drive at negedge, compute what the outputs must be after the next posedge.
   task automatic cyc(input logic [31:0] a, input logic [7:0] d, input logic wr,
                      input logic rv, input logic [7:0] rd, input logic tr);
      exp_t e;
      int   idx;
      logic io;
      logic [17:0] a18;
      logic full_before;
      logic pop, push, acc;
      @(negedge clk);
      mem_a = a; mem_dout = d; mem_wr = wr; rx_valid = rv; rx_data = rd; tx_ready = tr;
      a18 = a[17:0];
      idx = int'(a[16:0]);
      io  = (a[17:16] == 2'b11);
      full_before = (txq_m.size() >= DEPTH - 1);
      e.chk_din = 1'b1;
      e.din = 8'h00;
      e.ack = 1'b0;
      if (!io) begin
         if (ram_m.exists(idx)) e.din = ram_m[idx];
         else e.chk_din = 1'b0;
         if (wr) ram_m[idx] = d;
      end else if (wr) begin
         e.chk_din = 1'b0;
         if (a18 == 18'h30004) begin
            se_m = 1'b1;
            ec_m = d;
         end
      end else if (a18 == 18'h30000) begin
         e.din = rv ? rd : 8'h00;
         e.ack = rv;
      end else if (a18 == 18'h30004) begin
         e.din = {7'b000_0000, full_before};
      end
      pop  = (txq_m.size() != 0) && tr;
      push = io && wr && (a18 == 18'h30000);
      acc  = push && ((txq_m.size() < DEPTH) || pop);
      if (push && !acc) ovf_m = 1'b1;
      if (pop) void'(txq_m.pop_front());
      if (acc) txq_m.push_back(d);
      e.se  = se_m;
      e.ec  = ec_m;
      e.ovf = ovf_m;
      e.tv  = (txq_m.size() != 0);
      e.td  = e.tv ? txq_m[0] : 8'h00;
      e.bf  = (txq_m.size() >= DEPTH - 1);
      exp_q.push_back(e);
   endtask

   // Monitor: compare every cycle that has an expectation queued.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         if (mon_e.chk_din) chk("mem_din", mem_din, mon_e.din);
         chk("rx_ack", {7'b0, rx_ack}, {7'b0, mon_e.ack});
         chk("sim_end", {7'b0, sim_end}, {7'b0, mon_e.se});
         chk("end_code", end_code, mon_e.ec);
         chk("io_overflow", {7'b0, io_overflow}, {7'b0, mon_e.ovf});
         chk("tx_valid", {7'b0, tx_valid}, {7'b0, mon_e.tv});
         if (mon_e.tv) chk("tx_data", tx_data, mon_e.td);
         chk("io_buffer_full", {7'b0, io_buffer_full}, {7'b0, mon_e.bf});
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_mem_din"}, mem_din, 8'h00);
      chk({tag, "_rx_ack"}, {7'b0, rx_ack}, 8'h00);
      chk({tag, "_sim_end"}, {7'b0, sim_end}, 8'h00);
      chk({tag, "_end_code"}, end_code, 8'h00);
      chk({tag, "_io_overflow"}, {7'b0, io_overflow}, 8'h00);
      chk({tag, "_tx_valid"}, {7'b0, tx_valid}, 8'h00);
      chk({tag, "_io_buffer_full"}, {7'b0, io_buffer_full}, 8'h00);
   endtask

   // Assert reset between edges and check outputs clear immediately.
   task automatic mid_reset();
      @(negedge clk);
      #2;
      mem_wr = 1'b0; mem_a = 32'h0; tx_ready = 1'b0; rx_valid = 1'b0;
      rst = 1'b0;
      #1;
      check_reset_outputs("midrst");
      txq_m.delete();
      ovf_m = 1'b0; se_m = 1'b0; ec_m = 8'h00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      logic [31:0] a;
      logic [7:0]  d;
      int          kind;
      rst = 1'b0; mem_a = 32'h0; mem_dout = 8'h00; mem_wr = 1'b0;
      tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      #12;
      check_reset_outputs("rst");
      @(negedge clk);
      rst = 1'b1;

      // RAM write then read, and read-first on a same-address write
      cyc(32'h0001_0010 & 32'h0000_0010, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0);
      cyc(32'h0000_0010, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
      cyc(32'h0000_0020, 8'h11, 1'b1, 1'b0, 8'h00, 1'b0);
      cyc(32'h0000_0020, 8'h22, 1'b1, 1'b0, 8'h00, 1'b0);
      cyc(32'h0000_0020, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);

      // Fill TX FIFO with host stalled: 7th raises almost-full, 8th fits, 9th drops
      for (int i = 0; i < 9; i++) cyc(32'h0003_0000, 8'h60 + 8'(i), 1'b1, 1'b0, 8'h00, 1'b0);
      // Full FIFO with simultaneous pop still accepts
      cyc(32'h0003_0000, 8'h70, 1'b1, 1'b0, 8'h00, 1'b1);
      // Drain while polling the status register
      for (int i = 0; i < 10; i++) cyc(32'h0003_0004, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);

      // RX reads: two consecutive consumes, then nothing pending
      cyc(32'h0003_0000, 8'h00, 1'b0, 1'b1, 8'h41, 1'b0);
      cyc(32'h0003_0000, 8'h00, 1'b0, 1'b1, 8'h42, 1'b0);
      cyc(32'h0003_0000, 8'h00, 1'b0, 1'b0, 8'h55, 1'b0);
      // Other IO address reads zero, write ignored
      cyc(32'h0003_0008, 8'h99, 1'b1, 1'b0, 8'h00, 1'b0);
      cyc(32'h0003_0008, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
      // End register
      cyc(32'h0003_0004, 8'h03, 1'b1, 1'b0, 8'h00, 1'b0);
      cyc(32'h0003_0004, 8'h07, 1'b1, 1'b0, 8'h00, 1'b0);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         a = $urandom();
         kind = $urandom_range(0, 9);
         if (kind <= 5) begin
            a[17:16] = 2'($urandom_range(0, 2));
            a[15:6]  = 10'h000;
         end else if (kind <= 7) begin
            a[17:0] = 18'h30000;
         end else if (kind == 8) begin
            a[17:0] = 18'h30004;
         end else begin
            a[17:0] = 18'h30008 + 18'($urandom_range(0, 255));
         end
         d = 8'($urandom());
         cyc(a, d, 1'($urandom()), 1'($urandom()), 8'($urandom()), ($urandom_range(0, 3) == 0));
      end

      // Reset in the middle of a TX drain
      for (int i = 0; i < 5; i++) cyc(32'h0003_0000, 8'hC0 + 8'(i), 1'b1, 1'b0, 8'h00, 1'b0);
      cyc(32'h0003_0004, 8'h09, 1'b1, 1'b0, 8'h00, 1'b1);
      cyc(32'h0000_0000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
      mid_reset();
      cyc(32'h0003_0004, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
      cyc(32'h0000_0010, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
      cyc(32'h0000_0020, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);

      repeat (3) @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left unchecked", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
